// File: rtl/sevenseg_scan_driver_if.sv
// sevenseg_scan_driver_if: datapath-to-display bundle (load/value/ovf/blank in, scan pins out)
interface sevenseg_scan_driver_if;
  logic        load;
  logic [15:0] value;
  logic        ovf;
  logic        blank;
  logic        pending;
  logic [3:0]  AN;
  logic [6:0]  Out;
  logic        LED;
  modport master (output load, value, ovf, blank, input pending, AN, Out, LED);
  modport slave (input load, value, ovf, blank, output pending, AN, Out, LED);
endinterface

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: tear-free 4-digit multiplexed hex display driver; SEVENSEG_LZ_BLANK_EN suppresses leading zeros
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input logic                   clk,
  input logic                   reset,
  sevenseg_scan_driver_if.slave bus
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] HEX [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   disp_q, disp_d;
  logic          led_q, led_d;
  logic [16:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    out_q, out_d;
  logic          tick, frame_end, show;
`ifdef SEVENSEG_LZ_BLANK_EN
  assign show = (dig_q == 2'd0) || ((disp_q >> {dig_q, 2'b00}) != 16'd0);
`else
  assign show = 1'b1;
`endif
  always_comb begin
    tick = cnt_q == CW'(REFRESH_DIV - 1);
    frame_end = tick && dig_q == 2'd3;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    dig_d = dig_q + {1'b0, tick};
    an_d = (bus.blank || !show) ? 4'hF : ~(4'b0001 << dig_q);
    out_d = HEX[disp_q[{dig_q, 2'b00} +: 4]];
    disp_d = disp_q;
    led_d = led_q;
    shadow_d = shadow_q;
    pending_d = pending_q;
    // display only changes at frame boundaries so a frame never mixes old and new digits
    if (bus.load && frame_end) begin
      {led_d, disp_d} = {bus.ovf, bus.value};
      pending_d = 1'b0;
    end else if (frame_end && pending_q) begin
      {led_d, disp_d} = shadow_q;
      pending_d = 1'b0;
    end else if (bus.load) begin
      shadow_d = {bus.ovf, bus.value};
      pending_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      dig_q <= '0;
      disp_q <= '0;
      led_q <= 1'b0;
      shadow_q <= '0;
      pending_q <= 1'b0;
      an_q <= 4'hF;
      out_q <= 7'h7F;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      disp_q <= disp_d;
      led_q <= led_d;
      shadow_q <= shadow_d;
      pending_q <= pending_d;
      an_q <= an_d;
      out_q <= out_d;
    end
  end
  assign bus.pending = pending_q;
  assign bus.AN = an_q;
  assign bus.Out = out_q;
  assign bus.LED = led_q;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver: directed + random stimulus against a frame/slot arithmetic model
module tb_sevenseg_scan_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int t = 0;
  logic [15:0] m_disp = '0;
  logic        m_led = 1'b0;
  logic [16:0] m_sh = '0;
  logic        m_pend = 1'b0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_out = 7'h7F;
  logic [6:0]  hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  sevenseg_scan_driver_if bus ();
  sevenseg_scan_driver #(.REFRESH_DIV(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cycle(input logic ld, input logic [15:0] v, input logic o, input logic bl, input logic rs);
    int s;
    logic [3:0] nib;
    logic shown;
    logic fe;
    @(negedge clk);
    bus.load = ld;
    bus.value = v;
    bus.ovf = o;
    bus.blank = bl;
    reset = rs;
    @(posedge clk);
    if (rs) begin
      t = 0;
      m_disp = '0;
      m_led = 1'b0;
      m_sh = '0;
      m_pend = 1'b0;
      e_an = 4'hF;
      e_out = 7'h7F;
    end else begin
      s = (t / 4) % 4;
      nib = 4'((m_disp >> (4 * s)) & 16'hF);
      e_out = hex_tab[nib];
`ifdef SEVENSEG_LZ_BLANK_EN
      shown = (s == 0) || ((m_disp >> (4 * s)) != 0);
`else
      shown = 1'b1;
`endif
      e_an = (bl || !shown) ? 4'hF : ~(4'b0001 << s);
      fe = (t % 16) == 15;
      if (ld && fe) begin
        m_disp = v;
        m_led = o;
        m_pend = 1'b0;
      end else if (fe && m_pend) begin
        {m_led, m_disp} = m_sh;
        m_pend = 1'b0;
      end else if (ld) begin
        m_sh = {o, v};
        m_pend = 1'b1;
      end
      t++;
    end
    #1;
    chk("AN", 32'(bus.AN), 32'(e_an));
    chk("Out", 32'(bus.Out), 32'(e_out));
    chk("LED", 32'(bus.LED), 32'(m_led));
    chk("pending", 32'(bus.pending), 32'(m_pend));
  endtask
  task automatic step();
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic run_to(input int n);
    for (int i = 0; i < 16 && (t % 16) != n; i++) step();
  endtask
  initial begin
    bus.load = 1'b0;
    bus.value = '0;
    bus.ovf = 1'b0;
    bus.blank = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("reset_an", 32'(bus.AN), 32'h0000000F);
    chk("reset_out", 32'(bus.Out), 32'h0000007F);
    step();
    chk("first_an", 32'(bus.AN), 32'h0000000E);
    chk("first_out", 32'(bus.Out), 32'h00000040);
    for (int i = 0; i < 20; i++) step();
    run_to(5);
    cycle(1'b1, 16'h1A3F, 1'b1, 1'b0, 1'b0);
    chk("load_pending", 32'(bus.pending), 32'h1);
    run_to(1);
    chk("slot0_F", 32'(bus.Out), 32'h0000000E);
    chk("led_on", 32'(bus.LED), 32'h1);
    chk("pending_clr", 32'(bus.pending), 32'h0);
    run_to(5);
    chk("slot1_3", 32'(bus.Out), 32'h00000030);
    run_to(3);
    cycle(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
    run_to(8);
    cycle(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
    run_to(1);
    chk("last_wins", 32'(bus.Out), 32'h00000024);
    run_to(15);
    cycle(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    chk("fe_load_pending", 32'(bus.pending), 32'h0);
    step();
    chk("fe_load_slot0", 32'(bus.Out), 32'h0000000E);
    cycle(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 36; i++) step();
    run_to(9);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("midreset_an", 32'(bus.AN), 32'h0000000F);
    step();
    chk("restart_an", 32'(bus.AN), 32'h0000000E);
    for (int i = 0; i < 700; i++)
      cycle($urandom_range(0, 5) == 0, 16'($urandom), 1'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
